// File: rtl/mmio_hub.sv
// mmio_hub: MMIO decoder between the datapath data port and dmem.
// Stores to console DATA registers are queued in per-channel FIFOs that a
// sink drains with valid/ready. A sticky test-status register records the
// first pass/fail result. Every other access passes through to dmem.
module mmio_hub #(
    parameter int              XLEN           = 32,
    parameter int              NCHAN          = 2,
    parameter int              FIFO_DEPTH     = 8,
    parameter logic [XLEN-1:0] CONSOLE_BASE   = XLEN'(32'h1000_0000),
    parameter logic [XLEN-1:0] CHAN_STRIDE    = XLEN'(32'h10),
    parameter logic [XLEN-1:0] TEST_STAT_ADDR = XLEN'(32'h2000_0000),
    parameter logic [XLEN-1:0] PASS_MAGIC     = XLEN'(123456789)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         cpu_addr,
    input  logic [XLEN-1:0]         cpu_wdata,
    input  logic                    cpu_we,
    output logic [XLEN-1:0]         cpu_rdata,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic [XLEN-1:0]         mem_wdata,
    output logic                    mem_we,
    output logic [NCHAN-1:0]        console_valid,
    output logic [NCHAN*XLEN-1:0]   console_data,
    input  logic [NCHAN-1:0]        console_ready,
    output logic [NCHAN-1:0]        overflow,
    output logic                    test_passed,
    output logic                    test_failed,
    output logic [XLEN-1:0]         test_code
);

    // Pointer width and occupancy width (occupancy must reach FIFO_DEPTH).
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [NCHAN-1:0] data_hit;
    logic [NCHAN-1:0] stat_hit;
    logic [XLEN-1:0]  stat_word [NCHAN];
    logic             test_hit;
    logic             mmio_hit;
    logic [XLEN-1:0]  mmio_rdata;

    logic             test_passed_q, test_passed_d;
    logic             test_failed_q, test_failed_d;
    logic [XLEN-1:0]  test_code_q, test_code_d;

    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan
            localparam logic [XLEN-1:0] DATA_ADDR = CONSOLE_BASE + CHAN_STRIDE * XLEN'(gi);
            localparam logic [XLEN-1:0] STAT_ADDR = DATA_ADDR + XLEN'(4);

            logic [XLEN-1:0] mem_q [FIFO_DEPTH];
            logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]   count_q, count_d;
            logic            ovf_q, ovf_d;
            logic            full;
            logic            valid;
            logic            push_req;
            logic            push;
            logic            pop;

            assign data_hit[gi] = (cpu_addr == DATA_ADDR);
            assign stat_hit[gi] = (cpu_addr == STAT_ADDR);

            assign full     = (count_q == CW'(FIFO_DEPTH));
            assign valid    = (count_q != '0);
            assign pop      = valid & console_ready[gi];
            assign push_req = cpu_we & data_hit[gi];
            // A full FIFO still accepts a store when the head leaves in the same cycle.
            assign push     = push_req & (~full | pop);

            // Next-state for pointers, occupancy and the sticky drop flag.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q + CW'(push) - CW'(pop);
                ovf_d    = ovf_q | (push_req & ~push);
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end

            // Storage write; contents need no reset since the output is gated by valid.
            always_ff @(posedge clk) begin
                if (!reset && push) begin
                    mem_q[wr_ptr_q] <= cpu_wdata;
                end
            end

            // Channel control registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    ovf_q    <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    ovf_q    <= ovf_d;
                end
            end

            assign console_valid[gi]                = valid;
            assign console_data[gi*XLEN +: XLEN]    = valid ? mem_q[rd_ptr_q] : '0;
            assign overflow[gi]                     = ovf_q;
            assign stat_word[gi]                    = XLEN'({ovf_q, full, count_q});
        end
    endgenerate

    assign test_hit = (cpu_addr == TEST_STAT_ADDR);
    assign mmio_hit = (|data_hit) | (|stat_hit) | test_hit;

    // Read mux for MMIO registers; DATA registers read as zero.
    always_comb begin
        mmio_rdata = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (stat_hit[i]) begin
                mmio_rdata = stat_word[i];
            end
        end
        if (test_hit) begin
            mmio_rdata = XLEN'({test_failed_q, test_passed_q});
        end
    end

    // Dmem pass-through, suppressed on any MMIO hit.
    always_comb begin
        mem_we    = cpu_we & ~mmio_hit;
        mem_wdata = mmio_hit ? '0 : cpu_wdata;
        cpu_rdata = mmio_hit ? mmio_rdata : mem_rdata;
    end

    // Test status next-state: only the first TEST store is recorded.
    always_comb begin
        test_passed_d = test_passed_q;
        test_failed_d = test_failed_q;
        test_code_d   = test_code_q;
        if (cpu_we && test_hit && !test_passed_q && !test_failed_q) begin
            if (cpu_wdata == PASS_MAGIC) begin
                test_passed_d = 1'b1;
            end else begin
                test_failed_d = 1'b1;
                test_code_d   = cpu_wdata;
            end
        end
    end

    // Test status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            test_passed_q <= 1'b0;
            test_failed_q <= 1'b0;
            test_code_q   <= '0;
        end else begin
            test_passed_q <= test_passed_d;
            test_failed_q <= test_failed_d;
            test_code_q   <= test_code_d;
        end
    end

    assign test_passed = test_passed_q;
    assign test_failed = test_failed_q;
    assign test_code   = test_code_q;

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed test-plan sequences plus randomized traffic, checked
// every cycle against a queue-based behavioural model of the hub.
module tb_mmio_hub;

    localparam int          XLEN   = 32;
    localparam int          NCHAN  = 2;
    localparam int          DEPTH  = 8;
    localparam int          CW     = 4;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h10;
    localparam logic [31:0] TADDR  = 32'h2000_0000;
    localparam logic [31:0] MAGIC  = 32'd123456789;

    logic                  clk;
    logic                  reset;
    logic [XLEN-1:0]       cpu_addr;
    logic [XLEN-1:0]       cpu_wdata;
    logic                  cpu_we;
    logic [XLEN-1:0]       cpu_rdata;
    logic [XLEN-1:0]       mem_rdata;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_we;
    logic [NCHAN-1:0]      console_valid;
    logic [NCHAN*XLEN-1:0] console_data;
    logic [NCHAN-1:0]      console_ready;
    logic [NCHAN-1:0]      overflow;
    logic                  test_passed;
    logic                  test_failed;
    logic [XLEN-1:0]       test_code;

    int tests = 0;
    int fails = 0;
    bit verbose = 1'b1;

    mmio_hub #(
        .XLEN(XLEN), .NCHAN(NCHAN), .FIFO_DEPTH(DEPTH),
        .CONSOLE_BASE(BASE), .CHAN_STRIDE(STRIDE),
        .TEST_STAT_ADDR(TADDR), .PASS_MAGIC(MAGIC)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .console_valid(console_valid), .console_data(console_data),
        .console_ready(console_ready), .overflow(overflow),
        .test_passed(test_passed), .test_failed(test_failed),
        .test_code(test_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mq [NCHAN][$];
    bit          m_ovf [NCHAN];
    bit          m_pass;
    bit          m_fail;
    logic [31:0] m_code;

    function automatic int chan_of(input logic [31:0] a, input logic [31:0] off);
        for (int c = 0; c < NCHAN; c++) begin
            if (a == BASE + STRIDE * c + off) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] status_of(input int c);
        int n;
        n = mq[c].size();
        return (m_ovf[c] ? 32'(1 << (CW + 1)) : 32'd0)
             + ((n == DEPTH) ? 32'(1 << CW) : 32'd0)
             + 32'(n);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin : compare
        int          dc, sc;
        bit          th, hit, pop, full;
        logic [31:0] e_rd;
        logic [63:0] e_data;
        logic [NCHAN-1:0] e_valid, e_ovf;

        dc  = chan_of(cpu_addr, 32'd0);
        sc  = chan_of(cpu_addr, 32'd4);
        th  = (cpu_addr == TADDR);
        hit = (dc >= 0) || (sc >= 0) || th;

        if (!hit)        e_rd = mem_rdata;
        else if (sc >= 0) e_rd = status_of(sc);
        else if (th)     e_rd = {30'd0, m_fail, m_pass};
        else             e_rd = 32'd0;

        e_data = '0;
        for (int c = 0; c < NCHAN; c++) begin
            e_valid[c] = (mq[c].size() != 0);
            e_ovf[c]   = m_ovf[c];
            if (mq[c].size() != 0) e_data[c*XLEN +: XLEN] = mq[c][0];
        end

        chk("cpu_rdata", 64'(cpu_rdata), 64'(e_rd));
        chk("mem_we", 64'(mem_we), 64'(cpu_we && !hit));
        chk("mem_wdata", 64'(mem_wdata), hit ? 64'd0 : 64'(cpu_wdata));
        chk("console_valid", 64'(console_valid), 64'(e_valid));
        chk("console_data", 64'(console_data), e_data);
        chk("overflow", 64'(overflow), 64'(e_ovf));
        chk("test_passed", 64'(test_passed), 64'(m_pass));
        chk("test_failed", 64'(test_failed), 64'(m_fail));
        chk("test_code", 64'(test_code), 64'(m_code));

        if (reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
            end
            m_pass = 1'b0;
            m_fail = 1'b0;
            m_code = 32'd0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                pop  = (mq[c].size() != 0) && console_ready[c];
                full = (mq[c].size() == DEPTH);
                if (pop) void'(mq[c].pop_front());
                if (cpu_we && dc == c) begin
                    if (full && !pop) m_ovf[c] = 1'b1;
                    else              mq[c].push_back(cpu_wdata);
                end
            end
            if (cpu_we && th && !m_pass && !m_fail) begin
                if (cpu_wdata == MAGIC) m_pass = 1'b1;
                else begin
                    m_fail = 1'b1;
                    m_code = cpu_wdata;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit we, input logic [NCHAN-1:0] rdy);
        @(posedge clk);
        #1;
        reset         = r;
        cpu_addr      = a;
        cpu_wdata     = d;
        cpu_we        = we;
        console_ready = rdy;
        mem_rdata     = $urandom;
        if (verbose)
            $display("[TB] t=%0t rst=%0b addr=%h we=%0b wdata=%h ready=%b",
                     $time, r, a, we, d, rdy);
        @(negedge clk);
    endtask

    localparam logic [31:0] D0 = BASE;
    localparam logic [31:0] S0 = BASE + 32'h4;
    localparam logic [31:0] D1 = BASE + STRIDE;
    localparam logic [31:0] S1 = BASE + STRIDE + 32'h4;
    localparam logic [31:0] IDLE = 32'h0000_0000;

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
        console_ready = '0; mem_rdata = '0;
        step(1, IDLE, 0, 0, 2'b00);
        chk("reset_valid", 64'(console_valid), 64'd0);

        // Three pushes on ch0, then status and in-order drain.
        step(0, D0, 32'h41, 1, 2'b00);
        step(0, D0, 32'h42, 1, 2'b00);
        step(0, D0, 32'h43, 1, 2'b00);
        step(0, S0, 0, 0, 2'b00);
        chk("ch0_status_3", 64'(cpu_rdata), 64'd3);
        step(0, IDLE, 0, 0, 2'b01);
        chk("ch0_head_41", 64'(console_data[31:0]), 64'h41);
        step(0, IDLE, 0, 0, 2'b01);
        chk("ch0_head_42", 64'(console_data[31:0]), 64'h42);
        step(0, IDLE, 0, 0, 2'b01);
        chk("ch0_head_43", 64'(console_data[31:0]), 64'h43);
        step(0, IDLE, 0, 0, 2'b01);
        chk("ch0_drained", 64'(console_valid[0]), 64'd0);

        // Overflow on ch1: nine pushes into eight entries.
        for (int k = 1; k <= 9; k++) step(0, D1, 32'(k), 1, 2'b00);
        step(0, S1, 0, 0, 2'b00);
        chk("ch1_status_ovf", 64'(cpu_rdata), 64'h38);
        chk("ch1_overflow", 64'(overflow[1]), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            step(0, IDLE, 0, 0, 2'b10);
            chk("ch1_drain_word", 64'(console_data[63:32]), 64'(k));
        end
        step(0, IDLE, 0, 0, 2'b10);
        chk("ch1_no_9th", 64'(console_valid[1]), 64'd0);

        // Full ch0 accepts a store when a pop happens in the same cycle.
        step(1, IDLE, 0, 0, 2'b00);
        for (int k = 0; k < 8; k++) step(0, D0, 32'h100 + 32'(k), 1, 2'b00);
        step(0, D0, 32'h99, 1, 2'b01);
        step(0, S0, 0, 0, 2'b00);
        chk("ch0_full_pop_push", 64'(cpu_rdata), 64'h18);
        chk("ch0_no_ovf", 64'(overflow[0]), 64'd0);
        chk("ch0_head_101", 64'(console_data[31:0]), 64'h101);
        for (int k = 0; k < 9; k++) step(0, IDLE, 0, 0, 2'b01);

        // Pass then ignored store.
        step(1, IDLE, 0, 0, 2'b00);
        step(0, TADDR, MAGIC, 1, 2'b00);
        step(0, TADDR, 32'd5, 1, 2'b00);
        step(0, TADDR, 0, 0, 2'b00);
        chk("test_read_pass", 64'(cpu_rdata), 64'd1);
        chk("passed_set", 64'(test_passed), 64'd1);
        chk("failed_clear", 64'(test_failed), 64'd0);

        // Fail wins, later magic ignored.
        step(1, IDLE, 0, 0, 2'b00);
        step(0, TADDR, 32'hDEAD, 1, 2'b00);
        step(0, TADDR, MAGIC, 1, 2'b00);
        step(0, IDLE, 0, 0, 2'b00);
        chk("failed_set", 64'(test_failed), 64'd1);
        chk("fail_code", 64'(test_code), 64'hDEAD);
        chk("pass_blocked", 64'(test_passed), 64'd0);

        // Pass-through store, then reset mid-drain.
        step(0, 32'h0000_0100, 32'h55, 1, 2'b00);
        chk("pt_mem_we", 64'(mem_we), 64'd1);
        chk("pt_mem_wdata", 64'(mem_wdata), 64'h55);
        step(0, D0, 32'h1, 1, 2'b00);
        step(0, D0, 32'h2, 1, 2'b00);
        step(0, S0, 0, 0, 2'b00);
        chk("ch0_two_words", 64'(cpu_rdata), 64'd2);
        step(1, IDLE, 0, 0, 2'b01);
        step(0, S0, 0, 0, 2'b00);
        chk("rst_valid", 64'(console_valid[0]), 64'd0);
        chk("rst_count", 64'(cpu_rdata), 64'd0);

        // Randomized traffic.
        verbose = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            int          sel, ch;
            logic [31:0] a, d;
            bit          we, r;
            logic [NCHAN-1:0] rdy;
            sel = int'($urandom_range(0, 11));
            ch  = int'($urandom_range(0, NCHAN - 1));
            d   = $urandom;
            if (sel <= 4)       a = BASE + STRIDE * ch;
            else if (sel <= 6)  a = BASE + STRIDE * ch + 32'h4;
            else if (sel == 7) begin
                a = TADDR;
                if ($urandom_range(0, 3) == 0) d = MAGIC;
            end else            a = {16'd0, 16'($urandom)};
            we  = ($urandom_range(0, 9) < 7);
            // Alternate slow and fast sinks so FIFOs both fill and drain.
            rdy = ((n / 200) % 2 == 0) ? NCHAN'($urandom & $urandom & $urandom)
                                       : NCHAN'($urandom);
            r   = ($urandom_range(0, 499) == 0);
            step(r, a, d, we, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
